// File: rtl/branch_rs_gen2.sv
// branch_rs_gen2: branch reservation station.
// Buffers up to DEPTH branch instructions, wakes their operands from NCDB
// broadcast ports, and issues the oldest fully-ready entry into a registered
// valid/ready issue stage. A synchronous flush clears everything.
module branch_rs_gen2 #(
    parameter int DEPTH  = 8,
    parameter int NCDB   = 2,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NCDB-1:0]              cdb_en,
    input  logic [NCDB*TAG_W-1:0]        cdb_tag,
    input  logic [NCDB*DATA_W-1:0]       cdb_data,
    input  logic                         in_en,
    input  logic [OP_W-1:0]              in_op,
    input  logic [DATA_W-1:0]            in_data_o,
    input  logic [DATA_W-1:0]            in_data_t,
    input  logic [TAG_W-1:0]             in_tag_o,
    input  logic [TAG_W-1:0]             in_tag_t,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [ADDR_W-1:0]            in_pc,
    output logic                         in_ready,
    output logic [$clog2(DEPTH+1)-1:0]   free_count,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [OP_W-1:0]              ex_op,
    output logic [DATA_W-1:0]            ex_data_o,
    output logic [DATA_W-1:0]            ex_data_t,
    output logic [DATA_W-1:0]            ex_imm,
    output logic [ADDR_W-1:0]            ex_pc
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage
    logic [DEPTH-1:0]  valid_r;
    logic [OP_W-1:0]   op_r     [DEPTH];
    logic [TAG_W-1:0]  tag_o_r  [DEPTH];
    logic [DATA_W-1:0] data_o_r [DEPTH];
    logic [TAG_W-1:0]  tag_t_r  [DEPTH];
    logic [DATA_W-1:0] data_t_r [DEPTH];
    logic [DATA_W-1:0] imm_r    [DEPTH];
    logic [ADDR_W-1:0] pc_r     [DEPTH];
    // age_r[i][j] = 1 means entry j is older than entry i
    logic [DEPTH-1:0]  age_r    [DEPTH];

    // Combinational helpers
    logic [DEPTH-1:0]  ready_s;
    logic [DEPTH-1:0]  sel_onehot_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [IDX_W-1:0]  alloc_idx_s;
    logic              any_ready_s;
    logic              issue_s;
    logic              alloc_s;
    logic [CNT_W-1:0]  valid_cnt_s;
    logic [TAG_W-1:0]  wk_tag_o_s  [DEPTH];
    logic [DATA_W-1:0] wk_data_o_s [DEPTH];
    logic [TAG_W-1:0]  wk_tag_t_s  [DEPTH];
    logic [DATA_W-1:0] wk_data_t_s [DEPTH];
    logic [TAG_W-1:0]  byp_tag_o_s;
    logic [DATA_W-1:0] byp_data_o_s;
    logic [TAG_W-1:0]  byp_tag_t_s;
    logic [DATA_W-1:0] byp_data_t_s;

    // Resolve one operand against the broadcast ports. Returns {tag, data}.
    // Ports are scanned from high to low so the lowest matching port wins;
    // a waiting tag of zero is already ready and never matches.
    function automatic logic [TAG_W+DATA_W-1:0] wake(
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data
    );
        logic [TAG_W+DATA_W-1:0] res;
        logic                    hit;
        res = {tag, data};
        for (int k = NCDB-1; k >= 0; k--) begin
            hit = (tag != {TAG_W{1'b0}}) && cdb_en[k] &&
                  (cdb_tag[k*TAG_W +: TAG_W] == tag);
            res = hit ? {{TAG_W{1'b0}}, cdb_data[k*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    // Operand wakeup for stored entries and same-cycle bypass for dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wk_tag_o_s[i], wk_data_o_s[i]} = wake(tag_o_r[i], data_o_r[i]);
            {wk_tag_t_s[i], wk_data_t_s[i]} = wake(tag_t_r[i], data_t_r[i]);
        end
        {byp_tag_o_s, byp_data_o_s} = wake(in_tag_o, in_data_o);
        {byp_tag_t_s, byp_data_t_s} = wake(in_tag_t, in_data_t);
    end

    // Readiness, oldest-ready select, lowest-free allocation and occupancy
    always_comb begin
        ready_s      = '0;
        sel_onehot_s = '0;
        sel_idx_s    = '0;
        alloc_idx_s  = '0;
        valid_cnt_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = valid_r[i] && (tag_o_r[i] == {TAG_W{1'b0}}) &&
                         (tag_t_r[i] == {TAG_W{1'b0}});
        end
        for (int i = 0; i < DEPTH; i++) begin
            // No other ready entry is older than this one
            sel_onehot_s[i] = ready_s[i] && ((age_r[i] & ready_s) == {DEPTH{1'b0}});
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel_idx_s = sel_onehot_s[i] ? IDX_W'(i) : sel_idx_s;
        end
        for (int i = DEPTH-1; i >= 0; i--) begin
            alloc_idx_s = valid_r[i] ? alloc_idx_s : IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            valid_cnt_s = valid_cnt_s + CNT_W'(valid_r[i]);
        end
        any_ready_s = |ready_s;
        free_count  = CNT_W'(DEPTH) - valid_cnt_s;
        in_ready    = (free_count != {CNT_W{1'b0}});
        issue_s     = (!ex_valid || ex_ready) && any_ready_s;
        alloc_s     = in_en && in_ready && !flush;
    end

    // Entry array: allocation, wakeup capture, issue invalidation and age tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]     <= '0;
                tag_o_r[i]  <= '0;
                data_o_r[i] <= '0;
                tag_t_r[i]  <= '0;
                data_t_r[i] <= '0;
                imm_r[i]    <= '0;
                pc_r[i]     <= '0;
                age_r[i]    <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_s && (IDX_W'(i) == alloc_idx_s)) begin
                    valid_r[i]  <= 1'b1;
                    op_r[i]     <= in_op;
                    tag_o_r[i]  <= byp_tag_o_s;
                    data_o_r[i] <= byp_data_o_s;
                    tag_t_r[i]  <= byp_tag_t_s;
                    data_t_r[i] <= byp_data_t_s;
                    imm_r[i]    <= in_imm;
                    pc_r[i]     <= in_pc;
                end else begin
                    if (issue_s && (IDX_W'(i) == sel_idx_s)) begin
                        valid_r[i] <= 1'b0;
                    end else begin
                        valid_r[i] <= valid_r[i];
                    end
                    tag_o_r[i]  <= wk_tag_o_s[i];
                    data_o_r[i] <= wk_data_o_s[i];
                    tag_t_r[i]  <= wk_tag_t_s[i];
                    data_t_r[i] <= wk_data_t_s[i];
                end
            end
            if (alloc_s) begin
                // New entry is younger than everything valid; clear its stale column
                for (int i = 0; i < DEPTH; i++) begin
                    age_r[i][alloc_idx_s] <= 1'b0;
                end
                age_r[alloc_idx_s] <= valid_r;
            end else begin
                age_r <= age_r;
            end
        end
    end

    // Issue register: load from selected entry, drain on ready, hold on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_data_o <= '0;
            ex_data_t <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_data_o <= '0;
            ex_data_t <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
        end else if (issue_s) begin
            ex_valid  <= 1'b1;
            ex_op     <= op_r[sel_idx_s];
            ex_data_o <= data_o_r[sel_idx_s];
            ex_data_t <= data_t_r[sel_idx_s];
            ex_imm    <= imm_r[sel_idx_s];
            ex_pc     <= pc_r[sel_idx_s];
        end else if (ex_ready) begin
            ex_valid  <= 1'b0;
        end else begin
            ex_valid  <= ex_valid;
        end
    end

endmodule

// File: tb/tb_branch_rs_gen2.sv
// Scoreboard bench for branch_rs_gen2: directed dispatch/broadcast vectors
// push expected issues; a negedge monitor pops and compares on each handshake.
module tb_branch_rs_gen2;
    localparam int DEPTH  = 8;
    localparam int NCDB   = 2;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int OP_W   = 6;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic [NCDB-1:0]         cdb_en;
    logic [NCDB*TAG_W-1:0]   cdb_tag;
    logic [NCDB*DATA_W-1:0]  cdb_data;
    logic                    in_en;
    logic [OP_W-1:0]         in_op;
    logic [DATA_W-1:0]       in_data_o;
    logic [DATA_W-1:0]       in_data_t;
    logic [TAG_W-1:0]        in_tag_o;
    logic [TAG_W-1:0]        in_tag_t;
    logic [DATA_W-1:0]       in_imm;
    logic [ADDR_W-1:0]       in_pc;
    logic                    in_ready;
    logic [3:0]              free_count;
    logic                    ex_valid;
    logic                    ex_ready;
    logic [OP_W-1:0]         ex_op;
    logic [DATA_W-1:0]       ex_data_o;
    logic [DATA_W-1:0]       ex_data_t;
    logic [DATA_W-1:0]       ex_imm;
    logic [ADDR_W-1:0]       ex_pc;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] d_o;
        logic [DATA_W-1:0] d_t;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    branch_rs_gen2 #(
        .DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W),
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .in_en(in_en), .in_op(in_op), .in_data_o(in_data_o), .in_data_t(in_data_t),
        .in_tag_o(in_tag_o), .in_tag_t(in_tag_t), .in_imm(in_imm), .in_pc(in_pc),
        .in_ready(in_ready), .free_count(free_count),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_data_o(ex_data_o), .ex_data_t(ex_data_t), .ex_imm(ex_imm), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d_o,
                            input logic [DATA_W-1:0] d_t, input logic [DATA_W-1:0] imm,
                            input logic [ADDR_W-1:0] pc);
        exp_t e;
        e.op = op; e.d_o = d_o; e.d_t = d_t; e.imm = imm; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] to,
                            input logic [DATA_W-1:0] dto, input logic [TAG_W-1:0] tt,
                            input logic [DATA_W-1:0] dtt, input logic [DATA_W-1:0] imm,
                            input logic [ADDR_W-1:0] pc);
        in_en = 1'b1; in_op = op; in_tag_o = to; in_data_o = dto;
        in_tag_t = tt; in_data_t = dtt; in_imm = imm; in_pc = pc;
        tick();
        in_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", ex_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_pc",   64'(ex_pc),     64'(mon_e.pc));
                check("issue_op",   64'(ex_op),     64'(mon_e.op));
                check("issue_dat_o", 64'(ex_data_o), 64'(mon_e.d_o));
                check("issue_dat_t", 64'(ex_data_t), 64'(mon_e.d_t));
                check("issue_imm",  64'(ex_imm),    64'(mon_e.imm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0;
        cdb_en = '0; cdb_tag = '0; cdb_data = '0;
        in_en = 1'b0; in_op = '0; in_data_o = '0; in_data_t = '0;
        in_tag_o = '0; in_tag_t = '0; in_imm = '0; in_pc = '0;
        ex_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_ex_valid",   64'(ex_valid),   64'd0);
        check("rst_ex_pc",      64'(ex_pc),      64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_free_count", 64'(free_count), 64'd8);
        rst = 1'b0;
        tick();

        // T1: minimum latency
        ex_ready = 1'b1;
        push_exp(6'd1, 32'h0, 32'h0, 32'h0, 32'h100);
        dispatch(6'd1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h100);
        check("t1_not_yet",   64'(ex_valid),   64'd0);
        check("t1_free7",     64'(free_count), 64'd7);
        tick();
        check("t1_latency",   64'(ex_valid),   64'd1);
        check("t1_pc",        64'(ex_pc),      64'h100);
        check("t1_free8",     64'(free_count), 64'd8);
        wait_drain("t1_drain", 10);

        // T2: younger ready entry bypasses older waiting entry; wakeup on port 1
        push_exp(6'd3, 32'h33, 32'h44, 32'h66, 32'h300);
        push_exp(6'd2, 32'h55, 32'h11, 32'h22, 32'h200);
        dispatch(6'd2, 5'd3, 32'hDEAD, 5'd0, 32'h11, 32'h22, 32'h200);
        dispatch(6'd3, 5'd0, 32'h33, 5'd0, 32'h44, 32'h66, 32'h300);
        tick();
        cdb_en = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_data = {32'h55, 32'h0};
        tick();
        cdb_en = '0;
        wait_drain("t2_drain", 10);

        // T3: dispatch bypass on port 0; tag 0 on port 1 must not match
        cdb_en = 2'b11; cdb_tag = {5'd0, 5'd7}; cdb_data = {32'hDEAD, 32'hAB};
        push_exp(6'd4, 32'h1, 32'hAB, 32'h5, 32'h400);
        dispatch(6'd4, 5'd0, 32'h1, 5'd7, 32'h999, 32'h5, 32'h400);
        cdb_en = '0;
        tick();
        check("t3_bypass_valid", 64'(ex_valid),  64'd1);
        check("t3_bypass_data",  64'(ex_data_t), 64'hAB);
        // Both ports broadcast the same tag: port 0 wins
        push_exp(6'd7, 32'h1111, 32'h8, 32'h9, 32'h480);
        dispatch(6'd7, 5'd9, 32'h0, 5'd0, 32'h8, 32'h9, 32'h480);
        cdb_en = 2'b11; cdb_tag = {5'd9, 5'd9}; cdb_data = {32'h2222, 32'h1111};
        tick();
        cdb_en = '0;
        wait_drain("t3_drain", 10);

        // T4: fill, drop when full, ordered drain at full rate
        for (int i = 0; i < 8; i++) begin
            push_exp(6'd5, 32'h77, 32'(i), 32'h0, 32'h500 + 32'(i * 4));
            dispatch(6'd5, 5'd2, 32'h0, 5'd0, 32'(i), 32'h0, 32'h500 + 32'(i * 4));
        end
        check("t4_full_ready", 64'(in_ready),   64'd0);
        check("t4_full_count", 64'(free_count), 64'd0);
        dispatch(6'd5, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hBAD);
        check("t4_drop_count", 64'(free_count), 64'd0);
        cdb_en = 2'b01; cdb_tag = {5'd0, 5'd2}; cdb_data = {32'h0, 32'h77};
        tick();
        cdb_en = '0;
        check("t4_wake_latency", 64'(ex_valid), 64'd0);
        // Slot freed on this edge must not accept this cycle's dispatch
        dispatch(6'd5, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hBAD2);
        check("t4_free_after", 64'(free_count), 64'd1);
        check("t4_ready_after", 64'(in_ready),  64'd1);
        check("t4_first_issue", 64'(ex_valid),  64'd1);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t4_throughput", 64'(ex_valid), 64'd1);
        end
        tick();
        check("t4_empty_valid", 64'(ex_valid),   64'd0);
        check("t4_empty_count", 64'(free_count), 64'd8);
        wait_drain("t4_drain", 5);

        // T5: stall holds outputs; release shows next-oldest
        ex_ready = 1'b0;
        push_exp(6'd6, 32'h60, 32'h61, 32'h62, 32'h600);
        push_exp(6'd6, 32'h70, 32'h71, 32'h72, 32'h700);
        push_exp(6'd6, 32'h80, 32'h81, 32'h82, 32'h800);
        dispatch(6'd6, 5'd0, 32'h60, 5'd0, 32'h61, 32'h62, 32'h600);
        dispatch(6'd6, 5'd0, 32'h70, 5'd0, 32'h71, 32'h72, 32'h700);
        check("t5_hold_pc0", 64'(ex_pc), 64'h600);
        dispatch(6'd6, 5'd0, 32'h80, 5'd0, 32'h81, 32'h82, 32'h800);
        check("t5_hold_pc1", 64'(ex_pc), 64'h600);
        tick();
        check("t5_hold_pc2",  64'(ex_pc),     64'h600);
        check("t5_hold_dat",  64'(ex_data_o), 64'h60);
        check("t5_hold_valid", 64'(ex_valid), 64'd1);
        ex_ready = 1'b1;
        tick();
        check("t5_next_pc", 64'(ex_pc), 64'h700);
        wait_drain("t5_drain", 10);

        // T6: flush with occupied entries and a concurrent dispatch
        ex_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dispatch(6'd8, 5'd0, 32'(i), 5'd0, 32'h0, 32'h0, 32'h900 + 32'(i * 4));
        end
        check("t6_pre_count", 64'(free_count), 64'd4);
        check("t6_pre_valid", 64'(ex_valid),   64'd1);
        flush = 1'b1;
        dispatch(6'd9, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hF00);
        flush = 1'b0;
        check("t6_flush_count", 64'(free_count), 64'd8);
        check("t6_flush_valid", 64'(ex_valid),   64'd0);
        ex_ready = 1'b1;
        repeat (3) tick();
        check("t6_absent", 64'(ex_valid), 64'd0);

        // T7: asynchronous reset mid-handshake
        ex_ready = 1'b0;
        dispatch(6'd10, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hA00);
        dispatch(6'd10, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hA04);
        check("t7_pre_valid", 64'(ex_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_valid", 64'(ex_valid),   64'd0);
        check("t7_async_pc",    64'(ex_pc),      64'd0);
        check("t7_async_count", 64'(free_count), 64'd8);
        tick();
        rst = 1'b0;
        ex_ready = 1'b1;
        repeat (3) tick();
        check("t7_no_survivor", 64'(ex_valid), 64'd0);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
